mult_div_unit: RTL
==================

# mult_div_unit

Iterative signed multiply/divide unit for the multicycle MIPS datapath. It takes operands from the A and B registers, computes `mult` (64-bit product) or `div` (quotient and remainder) over 32 iteration cycles, and holds the result in its internal HI and LO registers. HI_out and LO_out feed the HI/LO inputs of the register-file write-data source multiplexer. The control unit starts each operation, waits on busy/done, and turns div_zero into the divide-by-zero exception.

## Interface
- No parameters. Data width is fixed at 32 bits; the product is 64 bits.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- md_start  in  1  start request. Sampled only in IDLE.
- md_op  in  1  operation select: 0 = mult, 1 = div. Both are signed.
- regA_out  in  32  multiplicand, or dividend for div.
- regB_out  in  32  multiplier, or divisor for div.
- HI_out  out  32  HI register. Upper product word for mult, remainder for div.
- LO_out  out  32  LO register. Lower product word for mult, quotient for div.
- md_busy  out  1  high while an operation is in progress.
- md_done  out  1  one-cycle pulse: result committed, or divide-by-zero abort.
- div_zero  out  1  one-cycle pulse together with md_done when a div has divisor 0.

## Operation
- States: IDLE, CALC, FIX. A 5-bit iteration counter runs in CALC.
- IDLE + md_start, no divide-by-zero:
  - latch |regA_out|, |regB_out|, the operand signs and md_op;
  - clear the accumulator and counter; go to CALC.
- IDLE + md_start + md_op=1 + regB_out==0:
  - stay in IDLE and pulse md_done and div_zero;
  - HI/LO unchanged; md_busy never rises.
- Operand capture: operands are captured on the start edge. Later changes on regA_out/regB_out have no effect.
- Magnitudes use two's-complement negation; |0x80000000| = 0x80000000 as unsigned.
- mult, in CALC:
  - unsigned shift-add, one multiplier bit per cycle, LSB first;
  - 64-bit {acc, multiplier} register with a 33-bit add carry.
- div, in CALC:
  - restoring division, one quotient bit per cycle, MSB first;
  - 33-bit partial remainder; trial subtract, restore when negative.
- CALC lasts exactly 32 cycles (counter 0..31), then moves to FIX.
- FIX:
  - mult: negate the 64-bit product if the operand signs differ.
  - div: negate the quotient if the signs differ; give the remainder the dividend's sign.
  - write HI/LO, pulse md_done, return to IDLE.
- Overflow case 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No exception is raised.
- md_start while in CALC or FIX is ignored. There is no queueing.
- Reset, asynchronous, at any time including mid-operation:
  - state goes to IDLE, counter to 0;
  - HI_out=0, LO_out=0, md_busy=0, md_done=0, div_zero=0;
  - any partial result is discarded.

## Timing
- Edge E0 samples md_start. md_busy is high from E0 through E33 (33 cycles).
- E1..E32 are the iterations. E33 executes FIX.
- HI_out/LO_out take the new value at E33. md_done=1 for exactly the cycle after E33; md_busy=0 in that same cycle.
- A new md_start may be sampled at E34 at the earliest.
- Divide-by-zero: md_done=div_zero=1 for the single cycle after E0.
- HI_out/LO_out change only at FIX or on reset.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Signed mult: mult 7 × 0xFFFFFFFD (−3) -> 33 cycles later HI=0xFFFFFFFF, LO=0xFFFFFFEB, md_done one cycle, div_zero=0.
- Extreme mult: mult 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0x00000000. Then mult 0xFFFFFFFF × 0xFFFFFFFF -> HI=0, LO=1.
- Signed div: div 0xFFFFFFF9 (−7) / 2 -> LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). Then div 100 / 0xFFFFFFF9 (−7) -> LO=0xFFFFFFF2 (−14), HI=2. Then div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: preload HI/LO with a mult result, then div 5 / 0 -> md_done=div_zero=1 in the cycle after start, md_busy stays 0, HI/LO unchanged.
- Start while busy:
  - second md_start with different operands at cycle 10 of a mult -> ignored; the first result is committed at the normal cycle;
  - changing regA_out/regB_out after E0 does not alter the result.
- Reset mid-operation: assert reset at cycle 20 of a div -> all outputs 0 immediately. After release, a fresh mult 3 × 4 -> HI=0, LO=12 with the full 33-cycle latency.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Handshake and operand/result bundle between the control unit and the
// iterative multiply/divide unit.
interface mult_div_unit_if;
  logic        md_start;
  logic        md_op;
  logic [31:0] regA_out;
  logic [31:0] regB_out;
  logic [31:0] HI_out;
  logic [31:0] LO_out;
  logic        md_busy;
  logic        md_done;
  logic        div_zero;

  modport master (
    output md_start,
    output md_op,
    output regA_out,
    output regB_out,
    input  HI_out,
    input  LO_out,
    input  md_busy,
    input  md_done,
    input  div_zero
  );

  modport slave (
    input  md_start,
    input  md_op,
    input  regA_out,
    input  regB_out,
    output HI_out,
    output LO_out,
    output md_busy,
    output md_done,
    output div_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit with HI/LO
// result registers. 32 iteration cycles plus one sign-fixup cycle.
module mult_div_unit (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave md
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        op_q, op_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  // acc: product upper half (mult) or partial remainder (div).
  // shreg: multiplier bits (mult) or dividend/quotient bits (div).
  // mag: multiplicand (mult) or divisor (div) magnitude.
  logic [31:0] acc_q, acc_d;
  logic [31:0] shreg_q, shreg_d;
  logic [31:0] mag_q, mag_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;

  logic [31:0] abs_a, abs_b;
  logic        start_dz;

  assign abs_a    = md.regA_out[31] ? (~md.regA_out + 32'd1) : md.regA_out;
  assign abs_b    = md.regB_out[31] ? (~md.regB_out + 32'd1) : md.regB_out;
  assign start_dz = md.md_op && (md.regB_out == 32'd0);

  // One shift-add step, LSB of the multiplier first.
  logic [32:0] mul_sum;
  logic [31:0] mul_acc_next;
  logic [31:0] mul_sh_next;

  always_comb begin
    mul_sum      = shreg_q[0] ? ({1'b0, acc_q} + {1'b0, mag_q}) : {1'b0, acc_q};
    mul_acc_next = mul_sum[32:1];
    mul_sh_next  = {mul_sum[0], shreg_q[31:1]};
  end

  // One restoring-division step; a borrow in bit 32 means the trial went negative.
  logic [32:0] div_shift;
  logic [32:0] div_trial;
  logic [31:0] div_acc_next;
  logic [31:0] div_sh_next;

  always_comb begin
    div_shift = {acc_q, shreg_q[31]};
    div_trial = div_shift - {1'b0, mag_q};
    if (div_trial[32]) begin
      div_acc_next = div_shift[31:0];
      div_sh_next  = {shreg_q[30:0], 1'b0};
    end else begin
      div_acc_next = div_trial[31:0];
      div_sh_next  = {shreg_q[30:0], 1'b1};
    end
  end

  // Sign fixup applied in the final cycle.
  logic [63:0] product;
  logic [63:0] product_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  always_comb begin
    product     = {acc_q, shreg_q};
    product_fix = (sign_a_q ^ sign_b_q) ? (~product + 64'd1) : product;
    quot_fix    = (sign_a_q ^ sign_b_q) ? (~shreg_q + 32'd1) : shreg_q;
    rem_fix     = sign_a_q ? (~acc_q + 32'd1) : acc_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    acc_d    = acc_q;
    shreg_d  = shreg_q;
    mag_d    = mag_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (md.md_start) begin
          if (start_dz) begin
            done_d = 1'b1;
            dz_d   = 1'b1;
          end else begin
            state_d  = StCalc;
            busy_d   = 1'b1;
            cnt_d    = 5'd0;
            acc_d    = 32'd0;
            op_d     = md.md_op;
            sign_a_d = md.regA_out[31];
            sign_b_d = md.regB_out[31];
            if (md.md_op) begin
              mag_d   = abs_b;
              shreg_d = abs_a;
            end else begin
              mag_d   = abs_a;
              shreg_d = abs_b;
            end
          end
        end
      end

      StCalc: begin
        cnt_d = cnt_q + 5'd1;
        if (op_q) begin
          acc_d   = div_acc_next;
          shreg_d = div_sh_next;
        end else begin
          acc_d   = mul_acc_next;
          shreg_d = mul_sh_next;
        end
        if (cnt_q == 5'd31) begin
          state_d = StFix;
        end
      end

      StFix: begin
        if (op_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = product_fix[63:32];
          lo_d = product_fix[31:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = 5'd0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        cnt_d   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      op_q     <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_q    <= 32'd0;
      shreg_q  <= 32'd0;
      mag_q    <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      acc_q    <= acc_d;
      shreg_q  <= shreg_d;
      mag_q    <= mag_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign md.HI_out   = hi_q;
  assign md.LO_out   = lo_q;
  assign md.md_busy  = busy_q;
  assign md.md_done  = done_q;
  assign md.div_zero = dz_q;

endmodule
